// File: rtl/lu_serial_ctrl_pkg.sv
// lu_serial_ctrl_pkg: shared op-select codes, FSM state encoding and the per-bit logic function
package lu_serial_ctrl_pkg;
   localparam logic [2:0] LU_OP_NOT  = 3'b000;
   localparam logic [2:0] LU_OP_AND  = 3'b001;
   localparam logic [2:0] LU_OP_NAND = 3'b010;
   localparam logic [2:0] LU_OP_OR   = 3'b011;
   localparam logic [2:0] LU_OP_NOR  = 3'b100;
   localparam logic [2:0] LU_OP_XOR  = 3'b101;
   localparam logic [2:0] LU_OP_XNOR = 3'b110;
   localparam logic [2:0] LU_OP_ZERO = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } lu_state_e;

   function automatic logic lu_fn(input logic a, input logic b, input logic [2:0] sel);
      return (sel == LU_OP_NOT)  ? ~a :
             (sel == LU_OP_AND)  ? (a & b) :
             (sel == LU_OP_NAND) ? ~(a & b) :
             (sel == LU_OP_OR)   ? (a | b) :
             (sel == LU_OP_NOR)  ? ~(a | b) :
             (sel == LU_OP_XOR)  ? (a ^ b) :
             (sel == LU_OP_XNOR) ? ~(a ^ b) : 1'b0;
   endfunction
endpackage

// File: rtl/lu_bit.sv
// lu_bit: combinational 1-bit logic cell shared by the serial sequencer
module lu_bit
   import lu_serial_ctrl_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic [2:0] sel_i,
   input  logic       neg_i,
   output logic       y_o
);
   // optional inversion of a, then the selected logic function
   always_comb y_o = lu_fn(neg_i ? ~a_i : a_i, b_i, sel_i);
endmodule

// File: rtl/lu_serial_ctrl.sv
// lu_serial_ctrl: bit-serial sequencer driving lu_bit LSB first; LU_SEQ_ZERO_FLAG_EN adds out_zero_o
module lu_serial_ctrl
   import lu_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic [2:0]       in_sel_i,
   input  logic             in_neg_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_res_o,
   output logic             busy_o
`ifdef LU_SEQ_ZERO_FLAG_EN
   ,
   output logic             out_zero_o
`endif
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   lu_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
   logic [2:0]       sel_q;
   logic             neg_q;
   logic [CW-1:0]    cnt_q;
   logic             bit_y, last;

   lu_bit u_bit (
      .a_i  (a_q[0]),
      .b_i  (b_q[0]),
      .sel_i(sel_q),
      .neg_i(neg_q),
      .y_o  (bit_y)
   );

   assign last      = (cnt_q == CW'(WIDTH - 1));
   assign res_d     = {bit_y, res_q[WIDTH-1:1]};
   assign out_res_o = res_q;

   // next state and handshake outputs, all decoded from the state register only
   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) state_d = RUN;
         end
         RUN: begin
            busy_o = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            busy_o      = 1'b1;
            out_valid_o = 1'b1;
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // latch operands on accept, then shift one bit per RUN edge with the result entering at the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= '0;
         neg_q <= 1'b0;
         res_q <= '0;
         cnt_q <= '0;
      end else if (state_q == IDLE && in_valid_i) begin
         a_q   <= in_a_i;
         b_q   <= in_b_i;
         sel_q <= in_sel_i;
         neg_q <= in_neg_i;
         cnt_q <= '0;
      end else if (state_q == RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         res_q <= res_d;
         cnt_q <= last ? cnt_q : cnt_q + CW'(1);
      end
   end

`ifdef LU_SEQ_ZERO_FLAG_EN
   logic zero_q;
   // zero flag tracks the shifting result; its last RUN update reflects the complete word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              zero_q <= 1'b0;
      else if (state_q == RUN) zero_q <= (res_d == '0);
   end
   assign out_zero_o = zero_q;
`endif
endmodule

// File: tb/tb_lu_serial_ctrl.sv
// tb_lu_serial_ctrl: directed scoreboard bench for lu_serial_ctrl (WIDTH=8), optional LU_SEQ_ZERO_FLAG_EN
module tb_lu_serial_ctrl;
   logic       clk, rst_n, in_valid, in_ready, in_neg, out_valid, out_ready, busy;
   logic [7:0] in_a, in_b, out_res, held;
   logic [2:0] in_sel;
`ifdef LU_SEQ_ZERO_FLAG_EN
   logic       out_zero;
`endif
   logic [7:0] exp_q[$];
   logic [7:0] last_exp;
   int         n_cmp, n_err;

   lu_serial_ctrl #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_a_i     (in_a),
      .in_b_i     (in_b),
      .in_sel_i   (in_sel),
      .in_neg_i   (in_neg),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_res_o  (out_res),
      .busy_o     (busy)
`ifdef LU_SEQ_ZERO_FLAG_EN
      ,
      .out_zero_o (out_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s, input logic n);
      logic [7:0] x;
      x = n ? ~a : a;
      case (s)
         3'd0:    return ~x;
         3'd1:    return x & b;
         3'd2:    return ~(x & b);
         3'd3:    return x | b;
         3'd4:    return ~(x | b);
         3'd5:    return x ^ b;
         3'd6:    return ~(x ^ b);
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic n);
      @(negedge clk);
      in_a = a; in_b = b; in_sel = s; in_neg = n; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back(model(a, b, s, n));
      check("accept_busy", busy, 1);
      check("accept_ready", in_ready, 0);
   endtask

   task automatic wait_done(input string tag, input bit scramble);
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (scramble) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            in_sel = 3'($urandom); in_neg = ~in_neg;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, 8);
      check("sb_size", exp_q.size(), 1);
      last_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check(tag, out_res, last_exp);
`ifdef LU_SEQ_ZERO_FLAG_EN
      check("zero_flag", out_zero, last_exp == 8'h00);
`endif
   endtask

   task automatic handshake();
      @(posedge clk);
      #1;
      check("hs_valid", out_valid, 0);
      check("hs_ready", in_ready, 1);
      check("hs_busy", busy, 0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_sel = '0; in_neg = 1'b0;
      #12;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(8'hF0, 8'h3C, 3'b001, 1'b0);
      wait_done("and", 0);
      check("and_const", out_res, 8'h30);
      handshake();
      issue(8'hA5, 8'h00, 3'b000, 1'b1);
      wait_done("not_neg", 0);
      check("not_neg_const", out_res, 8'hA5);
      handshake();
      issue(8'hFF, 8'h0F, 3'b101, 1'b0);
      wait_done("xor", 0);
      check("xor_const", out_res, 8'hF0);
      handshake();
      issue(8'h5A, 8'hC3, 3'b111, 1'b0);
      wait_done("zero_op", 0);
      handshake();
      issue(8'h01, 8'h00, 3'b011, 1'b0);
      wait_done("or_one", 0);
      handshake();
      issue(8'h96, 8'h3C, 3'b010, 1'b1);
      wait_done("nand_neg", 0);
      handshake();

      out_ready = 1'b0;
      issue(8'h3C, 8'hF0, 3'b110, 1'b0);
      wait_done("xnor_bp", 0);
      held = out_res;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_res", out_res, held);
         check("bp_ready", in_ready, 0);
         in_valid = (i == 1);
         in_a = 8'h11; in_b = 8'h22; in_sel = 3'b011;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      handshake();
      @(posedge clk);
      #1;
      check("bp_no_queue_busy", busy, 0);
      check("bp_no_queue_sb", exp_q.size(), 0);

      issue(8'h0F, 8'h55, 3'b001, 1'b0);
      wait_done("scrambled", 1);
      handshake();

      issue(8'hFF, 8'hFF, 3'b011, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(8'h0F, 8'h30, 3'b100, 1'b0);
      wait_done("nor_after_rst", 0);
      check("nor_const", out_res, 8'hC0);
      handshake();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
